// File: rtl/tt_um_csa_stream_adder.sv
// tt_um_csa_stream_adder: Tiny Tapeout top that accepts NIBBLES operand nibble
// pairs LSB-first, adds them with one 4-bit carry-select slice per cycle (carry
// chained across nibbles) and streams the sum nibbles back out LSB-first.
// Optional feature macro: CSA_OVF_FLAG_EN drives the two's-complement overflow
// flag on uio_out[7] during the out_last beat; without it that pin is tied 0.
module tt_um_csa_stream_adder #(
    parameter int NIBBLES = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] CNT_ZERO = IW'(1'b0);
    localparam logic [IW-1:0] CNT_ONE  = IW'(1'b1);
    localparam logic [IW-1:0] CNT_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ld_cnt;
    logic [IW-1:0]   w_ld_cnt_nxt;
    logic [IW-1:0]   r_k;
    logic [IW-1:0]   w_k_nxt;
    logic [3:0]      r_a   [DEPTH];
    logic [3:0]      r_b   [DEPTH];
    logic [3:0]      r_sum [DEPTH];
    logic [DEPTH-1:0] r_cout;
    logic            r_carry;
    logic [7:0]      r_uo_out;
    logic [7:0]      r_uio_out;
    logic [7:0]      w_uo_nxt;
    logic [7:0]      w_uio_nxt;
    logic            w_last_nxt;

    logic w_in_valid;
    logic w_cin;
    logic w_out_ready;
    logic w_abort;
    logic w_unused_uio;
    logic w_accept;
    logic w_calc;
    logic w_xfer;
    logic [3:0] w_a_k;
    logic [3:0] w_b_k;
    logic [4:0] w_s0;
    logic [4:0] w_s1;
    logic [4:0] w_sel;

    assign w_in_valid   = uio_in[0];
    assign w_cin        = uio_in[1];
    assign w_out_ready  = uio_in[2];
    assign w_abort      = uio_in[3];
    assign w_unused_uio = &{1'b0, uio_in[7:4]};

    // Handshakes: abort wins over any accept/transfer in the same cycle.
    // A send beat only transfers once it is actually visible on the pins.
    assign w_accept = ena & ~w_abort & (r_state == ST_LOAD) & w_in_valid;
    assign w_calc   = ena & ~w_abort & (r_state == ST_CALC);
    assign w_xfer   = ena & ~w_abort & (r_state == ST_SEND) & r_uio_out[5] & w_out_ready;

    // Carry-select slice: both candidate sums precomputed, carry register picks.
    assign w_a_k = r_a[r_k];
    assign w_b_k = r_b[r_k];
    assign w_s0  = {1'b0, w_a_k} + {1'b0, w_b_k};
    assign w_s1  = w_s0 + 5'd1;
    assign w_sel = r_carry ? w_s1 : w_s0;

`ifdef CSA_OVF_FLAG_EN
    logic       r_ovf;
    logic [3:0] w_lo0;
    logic [3:0] w_lo1;
    logic       w_c3;

    // Carry into the MSB of the top nibble, selected the same way as the sum.
    assign w_lo0 = {1'b0, w_a_k[2:0]} + {1'b0, w_b_k[2:0]};
    assign w_lo1 = w_lo0 + 4'd1;
    assign w_c3  = r_carry ? w_lo1[3] : w_lo0[3];

    // Capture overflow (carry into MSB xor carry out of MSB) on the top nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_calc && (r_k == CNT_LAST)) begin
            r_ovf <= w_c3 ^ w_sel[4];
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: LOAD -> CALC -> SEND -> LOAD, abort forces LOAD.
    always_comb begin
        w_state_nxt = r_state;
        if (!ena) begin
            w_state_nxt = r_state;
        end else if (w_abort) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept && (r_ld_cnt == CNT_LAST)) w_state_nxt = ST_CALC;
                    else                                    w_state_nxt = r_state;
                end
                ST_CALC: begin
                    if (r_k == CNT_LAST) w_state_nxt = ST_SEND;
                    else                 w_state_nxt = r_state;
                end
                ST_SEND: begin
                    if (w_xfer && (r_k == CNT_LAST)) w_state_nxt = ST_LOAD;
                    else                             w_state_nxt = r_state;
                end
                default: w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Next values of the load and nibble counters; both wrap to 0 on phase end.
    always_comb begin
        w_ld_cnt_nxt = r_ld_cnt;
        w_k_nxt      = r_k;
        if (!ena) begin
            w_ld_cnt_nxt = r_ld_cnt;
        end else if (w_abort) begin
            w_ld_cnt_nxt = CNT_ZERO;
            w_k_nxt      = CNT_ZERO;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) w_ld_cnt_nxt = (r_ld_cnt == CNT_LAST) ? CNT_ZERO : r_ld_cnt + CNT_ONE;
                    else          w_ld_cnt_nxt = r_ld_cnt;
                end
                ST_CALC: w_k_nxt = (r_k == CNT_LAST) ? CNT_ZERO : r_k + CNT_ONE;
                ST_SEND: begin
                    if (w_xfer) w_k_nxt = (r_k == CNT_LAST) ? CNT_ZERO : r_k + CNT_ONE;
                    else        w_k_nxt = r_k;
                end
                default: begin
                    w_ld_cnt_nxt = CNT_ZERO;
                    w_k_nxt      = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state; a SEND beat is shown one cycle after entry.
    always_comb begin
        w_uo_nxt   = 8'h00;
        w_uio_nxt  = 8'h00;
        w_last_nxt = 1'b0;
        case (w_state_nxt)
            ST_LOAD: w_uio_nxt[4] = 1'b1;
            ST_CALC: w_uio_nxt    = 8'h00;
            ST_SEND: begin
                if (r_state == ST_SEND) begin
                    w_last_nxt   = (w_k_nxt == CNT_LAST);
                    w_uo_nxt     = {3'(w_k_nxt), r_cout[w_k_nxt], r_sum[w_k_nxt]};
                    w_uio_nxt[5] = 1'b1;
                    w_uio_nxt[6] = w_last_nxt;
`ifdef CSA_OVF_FLAG_EN
                    w_uio_nxt[7] = w_last_nxt & r_ovf;
`endif
                end else begin
                    w_uo_nxt = 8'h00;
                end
            end
            default: w_uio_nxt = 8'h00;
        endcase
    end

    // Counter and output registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt  <= CNT_ZERO;
            r_k       <= CNT_ZERO;
            r_uo_out  <= 8'h00;
            r_uio_out <= 8'h00;
        end else if (ena) begin
            r_ld_cnt  <= w_ld_cnt_nxt;
            r_k       <= w_k_nxt;
            r_uo_out  <= w_uo_nxt;
            r_uio_out <= w_uio_nxt;
        end
    end

    // Operand and result buffers plus the chained carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i]   <= 4'h0;
                r_b[i]   <= 4'h0;
                r_sum[i] <= 4'h0;
            end
            r_cout  <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a[r_ld_cnt] <= ui_in[3:0];
                r_b[r_ld_cnt] <= ui_in[7:4];
                if (r_ld_cnt == CNT_ZERO) r_carry <= w_cin;
            end
            if (w_calc) begin
                r_sum[r_k]  <= w_sel[3:0];
                r_cout[r_k] <= w_sel[4];
                r_carry     <= w_sel[4];
            end
        end
    end

    assign uo_out  = r_uo_out;
    assign uio_out = r_uio_out;
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_csa_stream_adder.sv
// Directed testbench for tt_um_csa_stream_adder (NIBBLES = 4).
module tb_tt_um_csa_stream_adder;
    localparam int NIB = 4;
`ifdef CSA_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       in_valid, cin, out_ready, abort;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    int n_pass  = 0;
    int n_total = 0;

    // Vector table: A, B, cin, expected sum, expected per-nibble couts, expected ovf.
    logic [15:0] tv_a   [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    logic [15:0] tv_b   [4] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001};
    logic        tv_c   [4] = '{1'b0,     1'b1,     1'b0,     1'b0};
    logic [15:0] tv_s   [4] = '{16'h5555, 16'h0000, 16'h8000, 16'h0000};
    logic [3:0]  tv_co  [4] = '{4'b0000,  4'b1111,  4'b0111,  4'b1111};
    logic        tv_ovf [4] = '{1'b0,     1'b0,     1'b1,     1'b0};

    assign uio_in = {4'b0000, abort, out_ready, cin, in_valid};

    always #5 clk = ~clk;

    tt_um_csa_stream_adder #(.NIBBLES(NIB)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive NIB beats; cin is only meaningful on beat 0, so the others carry its inverse.
    task automatic feed_operand(input logic [15:0] a, input logic [15:0] b, input logic c, input bit gap);
        for (int i = 0; i < NIB; i++) begin
            ui_in    = {b[i*4 +: 4], a[i*4 +: 4]};
            cin      = (i == 0) ? c : ~c;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (gap && i != NIB - 1) tick();
        end
    endtask

    task automatic wait_valid(output int lat, output bit timed_out);
        lat = 0;
        while (uio_out[5] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        timed_out = (uio_out[5] !== 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
        in_valid = 1'b0; cin = 1'b0; out_ready = 1'b0; abort = 1'b0;
        tick(); tick();
        n_total++; if (uo_out !== 8'h00) $display("FAIL reset_uo_out: got %h expected 00", uo_out); else n_pass++;
        n_total++; if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h expected 00", uio_out); else n_pass++;
        n_total++; if (uio_oe !== 8'hF0) $display("FAIL reset_uio_oe: got %h expected f0", uio_oe); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (uio_out !== 8'h00) $display("FAIL release_no_edge: got %h expected 00", uio_out); else n_pass++;
        tick();
        n_total++; if (uio_out !== 8'h10) $display("FAIL release_in_ready: got %h expected 10", uio_out); else n_pass++;
    endtask

    task automatic test_stream_sum;
        int lat;
        bit to;
        logic last;
        logic [7:0] exp_uo, exp_uio;
        for (int v = 0; v < 4; v++) begin
            out_ready = 1'b1;
            feed_operand(tv_a[v], tv_b[v], tv_c[v], 1'b0);
            wait_valid(lat, to);
            n_total++;
            if (to || lat != NIB + 1) $display("FAIL sum%0d_latency: got %0d expected %0d", v, lat, NIB + 1);
            else n_pass++;
            if (!to) begin
                for (int i = 0; i < NIB; i++) begin
                    last    = (i == NIB - 1);
                    exp_uo  = {3'(i), tv_co[v][i], tv_s[v][i*4 +: 4]};
                    exp_uio = {OVF_EN & tv_ovf[v] & last, last, 1'b1, 1'b0, 4'h0};
                    n_total++; if (uo_out !== exp_uo) $display("FAIL sum%0d_beat%0d_uo: got %h expected %h", v, i, uo_out, exp_uo); else n_pass++;
                    n_total++; if (uio_out !== exp_uio) $display("FAIL sum%0d_beat%0d_uio: got %h expected %h", v, i, uio_out, exp_uio); else n_pass++;
                    tick();
                end
            end
            n_total++; if (uio_out !== 8'h10) $display("FAIL sum%0d_back_to_load: got %h expected 10", v, uio_out); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bit to;
        logic last;
        logic [15:0] exp_s  = 16'hD6DE;
        logic [3:0]  exp_co = 4'b0100;
        logic [7:0]  exp_uo, exp_uio;
        out_ready = 1'b0;
        feed_operand(16'h9E27, 16'h38B6, 1'b1, 1'b0);
        wait_valid(lat, to);
        n_total++; if (to) $display("FAIL bp_valid_timeout: got 0 expected 1"); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++; if (uo_out !== 8'h0E) $display("FAIL bp_stall%0d_uo: got %h expected 0e", c, uo_out); else n_pass++;
            n_total++; if (uio_out !== 8'h20) $display("FAIL bp_stall%0d_uio: got %h expected 20", c, uio_out); else n_pass++;
        end
        ena = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++; if (uo_out !== 8'h0E) $display("FAIL ena_hold%0d_uo: got %h expected 0e", c, uo_out); else n_pass++;
        end
        ena = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            last    = (i == NIB - 1);
            exp_uo  = {3'(i), exp_co[i], exp_s[i*4 +: 4]};
            exp_uio = {1'b0, last, 1'b1, 1'b0, 4'h0};
            n_total++; if (uo_out !== exp_uo) $display("FAIL bp_beat%0d_uo: got %h expected %h", i, uo_out, exp_uo); else n_pass++;
            n_total++; if (uio_out !== exp_uio) $display("FAIL bp_beat%0d_uio: got %h expected %h", i, uio_out, exp_uio); else n_pass++;
            tick();
        end
        n_total++; if (uio_out !== 8'h10) $display("FAIL bp_back_to_load: got %h expected 10", uio_out); else n_pass++;
    endtask

    task automatic test_abort;
        int lat;
        bit to;
        logic last;
        logic [15:0] exp_s  = 16'h1010;
        logic [3:0]  exp_co = 4'b0101;
        logic [7:0]  exp_uo, exp_uio;
        out_ready = 1'b1;
        ui_in = 8'h99; cin = 1'b1; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        ui_in = 8'h77; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        abort = 1'b1; tick();
        abort = 1'b0;
        n_total++; if (uio_out !== 8'h10) $display("FAIL abort_to_load: got %h expected 10", uio_out); else n_pass++;
        feed_operand(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        wait_valid(lat, to);
        n_total++; if (to || lat != NIB + 1) $display("FAIL abort_latency: got %0d expected %0d", lat, NIB + 1); else n_pass++;
        for (int i = 0; i < NIB; i++) begin
            last    = (i == NIB - 1);
            exp_uo  = {3'(i), exp_co[i], exp_s[i*4 +: 4]};
            exp_uio = {1'b0, last, 1'b1, 1'b0, 4'h0};
            n_total++; if (uo_out !== exp_uo) $display("FAIL abort_beat%0d_uo: got %h expected %h", i, uo_out, exp_uo); else n_pass++;
            n_total++; if (uio_out !== exp_uio) $display("FAIL abort_beat%0d_uio: got %h expected %h", i, uio_out, exp_uio); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_send;
        int lat;
        bit to;
        out_ready = 1'b0;
        feed_operand(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_valid(lat, to);
        n_total++; if (to) $display("FAIL midrst_valid_timeout: got 0 expected 1"); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (uo_out !== 8'h00) $display("FAIL midrst_uo_out: got %h expected 00", uo_out); else n_pass++;
        n_total++; if (uio_out !== 8'h00) $display("FAIL midrst_uio_out: got %h expected 00", uio_out); else n_pass++;
        n_total++; if (uio_oe !== 8'hF0) $display("FAIL midrst_uio_oe: got %h expected f0", uio_oe); else n_pass++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (uio_out !== 8'h10) $display("FAIL midrst_in_ready: got %h expected 10", uio_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream_sum();
        test_backpressure();
        test_abort();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
